// File: rtl/pbus_pkg.sv
// Shared widths, FSM state type and frame layout for the pbus serial master/arbiter.
package pbus_pkg;

    localparam int unsigned ADDR_W  = 8;
    localparam int unsigned OP_W    = 3;
    localparam int unsigned DATA_W  = 62;
    localparam int unsigned FRAME_W = ADDR_W + OP_W + DATA_W;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_GAP
    } state_e;

    // Payload in wire order: the MSB of addr leaves the line first.
    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [OP_W-1:0]   op;
        logic [DATA_W-1:0] data;
    } frame_t;

    // Opcodes understood by pctrl nodes on the far side of the line.
    localparam logic [OP_W-1:0] OP_NOP   = 3'h0;
    localparam logic [OP_W-1:0] OP_READ  = 3'h1;
    localparam logic [OP_W-1:0] OP_WRITE = 3'h2;
    localparam logic [OP_W-1:0] OP_RMW   = 3'h3;
    localparam logic [OP_W-1:0] OP_BCAST = 3'h4;

    function automatic int unsigned idx_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/pbus_rr_pick.sv
// Combinational requester picker: round-robin from ptr_i, or fixed lowest-index
// priority when PBUS_ARB_FIXED_PRI_EN is defined (no pointer port in that build).
module pbus_rr_pick
    import pbus_pkg::*;
#(
    parameter int unsigned N_REQ = 4
)
(
    input  logic [N_REQ-1:0]        req_i,
`ifndef PBUS_ARB_FIXED_PRI_EN
    input  logic [idx_w(N_REQ)-1:0] ptr_i,
`endif
    output logic [N_REQ-1:0]        gnt_c_o,
    output logic [idx_w(N_REQ)-1:0] idx_c_o,
    output logic                    any_c_o
);

    localparam int unsigned IDX_W = idx_w(N_REQ);

    // Walk the requesters in priority order; the first one asserted wins.
    always_comb begin
        int unsigned j;
        logic        found;
        gnt_c_o = '0;
        idx_c_o = '0;
        found   = 1'b0;
        j       = 0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
`ifdef PBUS_ARB_FIXED_PRI_EN
            j = k;
`else
            j = (32'(ptr_i) + k) % N_REQ;
`endif
            if (!found && req_i[j[IDX_W-1:0]]) begin
                found                   = 1'b1;
                idx_c_o                 = j[IDX_W-1:0];
                gnt_c_o[j[IDX_W-1:0]]   = 1'b1;
            end
        end
        any_c_o = found;
    end

endmodule

// File: rtl/pbus_arb.sv
// pbus serial master: arbitrates N_REQ requesters and serialises one 74-bit frame at a time
// onto tx with idle-high guard cycles. PBUS_ARB_FIXED_PRI_EN selects fixed priority.
module pbus_arb
    import pbus_pkg::*;
#(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned GAP   = 2
)
(
    input  logic                       clk,
    input  logic                       nRst,
    input  logic [N_REQ-1:0]           req,
    input  logic [N_REQ*ADDR_W-1:0]    address_in,
    input  logic [N_REQ*OP_W-1:0]      opcode_in,
    input  logic [N_REQ*DATA_W-1:0]    data_in,
    output logic [N_REQ-1:0]           grant,
    output logic                       busy,
    output logic                       done,
    output logic                       tx
);

    localparam int unsigned IDX_W = idx_w(N_REQ);
    localparam int unsigned CNT_W = ($clog2(GAP) > $clog2(FRAME_W)) ? $clog2(GAP) : $clog2(FRAME_W);

    state_e               state_q, state_d;
    logic [FRAME_W-1:0]   shreg_q, shreg_d;
    logic [CNT_W-1:0]     cnt_q,   cnt_d;
    logic [N_REQ-1:0]     grant_q, grant_d;
    logic                 tx_q,    tx_d;
    logic                 busy_q,  busy_d;
    logic                 done_q,  done_d;

    logic [N_REQ-1:0]     pick_gnt;
    logic [IDX_W-1:0]     pick_idx;
    logic                 pick_any;
    frame_t               frames [N_REQ];

    for (genvar k = 0; k < N_REQ; k++) begin : g_frame
        assign frames[k] = {address_in[k*ADDR_W +: ADDR_W],
                            opcode_in[k*OP_W +: OP_W],
                            data_in[k*DATA_W +: DATA_W]};
    end

`ifndef PBUS_ARB_FIXED_PRI_EN
    logic [IDX_W-1:0]     ptr_q, ptr_d;
`endif

    pbus_rr_pick #(
        .N_REQ   (N_REQ)
    ) u_pick (
        .req_i   (req),
`ifndef PBUS_ARB_FIXED_PRI_EN
        .ptr_i   (ptr_q),
`endif
        .gnt_c_o (pick_gnt),
        .idx_c_o (pick_idx),
        .any_c_o (pick_any)
    );

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            state_q <= ST_IDLE;
            shreg_q <= '0;
            cnt_q   <= '0;
            grant_q <= '0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifndef PBUS_ARB_FIXED_PRI_EN
            ptr_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
            grant_q <= grant_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
`ifndef PBUS_ARB_FIXED_PRI_EN
            ptr_q   <= ptr_d;
`endif
        end
    end

    // IDLE arbitrates and emits the start bit; SHIFT sends 73 payload bits; GAP holds the line high.
    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        cnt_d   = cnt_q;
        grant_d = '0;
        tx_d    = tx_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
`ifndef PBUS_ARB_FIXED_PRI_EN
        ptr_d   = ptr_q;
`endif
        unique case (state_q)
            ST_IDLE: begin
                tx_d   = 1'b1;
                busy_d = 1'b0;
                if (pick_any) begin
                    grant_d = pick_gnt;
                    shreg_d = frames[pick_idx];
                    tx_d    = 1'b0;
                    busy_d  = 1'b1;
                    cnt_d   = CNT_W'(FRAME_W - 1);
                    state_d = ST_SHIFT;
`ifndef PBUS_ARB_FIXED_PRI_EN
                    ptr_d   = (32'(pick_idx) == N_REQ - 1) ? '0 : pick_idx + IDX_W'(1);
`endif
                end
            end
            ST_SHIFT: begin
                tx_d    = shreg_q[FRAME_W-1];
                shreg_d = {shreg_q[FRAME_W-2:0], 1'b0};
                cnt_d   = cnt_q - CNT_W'(1);
                if (cnt_q == '0) begin
                    cnt_d   = CNT_W'(GAP - 1);
                    state_d = ST_GAP;
                end
            end
            ST_GAP: begin
                tx_d   = 1'b1;
                done_d = (cnt_q == CNT_W'(GAP - 1));
                cnt_d  = cnt_q - CNT_W'(1);
                if (cnt_q == '0) begin
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign grant = grant_q;
    assign busy  = busy_q;
    assign done  = done_q;
    assign tx    = tx_q;

endmodule

// File: tb/tb_pbus_arb.sv
// Scoreboard bench for pbus_arb: a cycle-count arbitration model queues expected frames,
// a negedge monitor checks grant, tx bits, done and busy against them.
module tb_pbus_arb;
    import pbus_pkg::*;

    localparam int N_REQ = 4;
    localparam int GAP   = 2;
    localparam int FLEN  = FRAME_W + 1;

    typedef struct {
        int               cyc;
        logic [N_REQ-1:0] gnt;
        logic [FLEN-1:0]  bits;
    } exp_t;

    logic                    clk;
    logic                    nRst;
    logic [N_REQ-1:0]        req;
    logic [N_REQ*ADDR_W-1:0] address_in;
    logic [N_REQ*OP_W-1:0]   opcode_in;
    logic [N_REQ*DATA_W-1:0] data_in;
    logic [N_REQ-1:0]        grant;
    logic                    busy;
    logic                    done;
    logic                    tx;

    exp_t sb[$];
    int   rd;
    int   cyc;
    int   n_vec;
    int   n_err;
    bit   rand_data;
    bit   final_chk;
    bit   final_done;

    pbus_arb #(
        .N_REQ      (N_REQ),
        .GAP        (GAP)
    ) dut (
        .clk        (clk),
        .nRst       (nRst),
        .req        (req),
        .address_in (address_in),
        .opcode_in  (opcode_in),
        .data_in    (data_in),
        .grant      (grant),
        .busy       (busy),
        .done       (done),
        .tx         (tx)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference: a frame may start only once the previous one plus its gap has elapsed.
    initial begin : model
        int m_ptr;
        int m_next;
        cyc    = 0;
        m_ptr  = 0;
        m_next = 0;
        forever begin : edge_blk
            int   w;
            exp_t e;
            @(posedge clk);
            if (!nRst) begin
                m_ptr  = 0;
                m_next = 0;
            end else if (cyc >= m_next) begin
                w = -1;
                for (int k = 0; k < N_REQ; k++) begin
                    int j;
                    j = (m_ptr + k) % N_REQ;
                    if (w < 0 && req[j]) w = j;
                end
                if (w >= 0) begin
                    e.cyc    = cyc + 1;
                    e.gnt    = '0;
                    e.gnt[w] = 1'b1;
                    e.bits   = {1'b0, address_in[w*ADDR_W +: ADDR_W],
                                opcode_in[w*OP_W +: OP_W], data_in[w*DATA_W +: DATA_W]};
                    sb.push_back(e);
                    m_next   = cyc + FLEN + GAP;
`ifndef PBUS_ARB_FIXED_PRI_EN
                    m_ptr    = (w + 1) % N_REQ;
`endif
                end
            end
            cyc = cyc + 1;
        end
    end

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        n_vec = n_vec + 1;
        if (act !== exp) begin
            n_err = n_err + 1;
            $display("FAIL %s @cyc %0d: got %0h expected %0h", nm, cyc, act, exp);
        end
    endtask

    initial begin : monitor
        int   pos;
        exp_t cur;
        n_vec      = 0;
        n_err      = 0;
        rd         = 0;
        pos        = -1;
        final_done = 1'b0;
        cur.cyc    = 0;
        cur.gnt    = '0;
        cur.bits   = '0;
        forever begin
            @(negedge clk);
            if (!nRst) begin
                pos = -1;
                chk("rst_tx",    8'(tx),    8'd1);
                chk("rst_grant", 8'(grant), 8'd0);
                chk("rst_busy",  8'(busy),  8'd0);
                chk("rst_done",  8'(done),  8'd0);
            end else if (pos < 0) begin
                if (rd < sb.size() && sb[rd].cyc == cyc) begin
                    cur = sb[rd];
                    rd  = rd + 1;
                    chk("grant", 8'(grant), 8'(cur.gnt));
                    pos = 0;
                end else begin
                    chk("idle_grant", 8'(grant), 8'd0);
                    chk("idle_tx",    8'(tx),    8'd1);
                    chk("idle_done",  8'(done),  8'd0);
                    chk("idle_busy",  8'(busy),  8'd0);
                end
            end
            if (nRst && pos >= 0) begin
                if (pos < FLEN) begin
                    chk("tx_bit",     8'(tx),   8'(cur.bits[FLEN-1-pos]));
                    chk("frame_busy", 8'(busy), 8'd1);
                    chk("frame_done", 8'(done), 8'd0);
                    if (pos > 0) chk("frame_grant", 8'(grant), 8'd0);
                end else begin
                    chk("gap_tx",    8'(tx),    8'd1);
                    chk("gap_done",  8'(done),  8'(pos == FLEN));
                    chk("gap_busy",  8'(busy),  8'd1);
                    chk("gap_grant", 8'(grant), 8'd0);
                end
                pos = pos + 1;
                if (pos == FLEN + GAP) pos = -1;
            end
            if (final_chk && !final_done) begin
                chk("sb_drain", 8'(sb.size() - rd), 8'd0);
                final_done = 1'b1;
            end
        end
    end

    task automatic tick();
        @(negedge clk);
        if (rand_data) begin
            for (int k = 0; k < N_REQ; k++) begin
                address_in[k*ADDR_W +: ADDR_W] = 8'($urandom);
                opcode_in[k*OP_W +: OP_W]      = 3'($urandom);
                data_in[k*DATA_W +: DATA_W]    = 62'({$urandom, $urandom});
            end
        end
    endtask

    task automatic wait_grant(input int k, input int limit);
        for (int i = 0; i < limit && !grant[k]; i++) tick();
    endtask

    initial begin : stim
        nRst       = 1'b0;
        req        = '0;
        address_in = '0;
        opcode_in  = '0;
        data_in    = '0;
        rand_data  = 1'b0;
        final_chk  = 1'b0;
        repeat (3) tick();
        nRst = 1'b1;
        repeat (3) tick();

        // Single directed frame from requester 0.
        address_in[0 +: ADDR_W] = 8'hAA;
        opcode_in[0 +: OP_W]    = OP_BCAST;
        data_in[0 +: DATA_W]    = 62'd100;
        req[0] = 1'b1;
        wait_grant(0, 5);
        req[0] = 1'b0;
        repeat (90) tick();

        // Three simultaneous requesters held through several frames.
        rand_data = 1'b1;
        req = 4'b1011;
        repeat (4 * (FLEN + GAP)) tick();
        req = '0;
        repeat (90) tick();

        // Late request mid-frame, then a request pulsed only during the guard gap.
        req[0] = 1'b1;
        wait_grant(0, 5);
        req[0] = 1'b0;
        repeat (10) tick();
        req[2] = 1'b1;
        wait_grant(2, 200);
        req[2] = 1'b0;
        for (int i = 0; i < 200 && !done; i++) tick();
        req[1] = 1'b1;
        tick();
        req[1] = 1'b0;
        repeat (20) tick();

        // Random traffic: requests appear, sometimes withdraw, sometimes re-request after grant.
        for (int c = 0; c < 3000; c++) begin
            tick();
            for (int k = 0; k < N_REQ; k++) begin
                if (req[k]) begin
                    if (grant[k]) begin
                        if ($urandom_range(1, 0) == 0) req[k] = 1'b0;
                    end else if ($urandom_range(199, 0) == 0) begin
                        req[k] = 1'b0;
                    end
                end else if ($urandom_range(29, 0) == 0) begin
                    req[k] = 1'b1;
                end
            end
        end
        req = '0;
        repeat (90) tick();

        // Asynchronous reset thirty cycles into a frame with requester 3 pending.
        req[0] = 1'b1;
        wait_grant(0, 5);
        req[0] = 1'b0;
        repeat (29) tick();
        req[3] = 1'b1;
        @(posedge clk);
        #2 nRst = 1'b0;
        repeat (3) tick();
        nRst = 1'b1;
        wait_grant(3, 10);
        req[3] = 1'b0;
        repeat (100) tick();

        final_chk = 1'b1;
        repeat (3) tick();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/pbus_arb.md
Name: pbus_arb

Overview:
- Serial-bus master and arbiter. Shares one pctrl-format serial line (`tx`) between N_REQ local requesters.
- Each requester presents an 8-bit node address, a 3-bit opcode and a 62-bit data word.
- The block grants one requester at a time, round-robin, and serialises its frame onto `tx`.
- Inserts idle-high guard cycles between frames. Sits upstream of the `rx` input of every pctrl node on the bus.

Parameters:
- N_REQ, 4, number of requesters (2..8)
- GAP, 2, idle-high cycles forced after each frame (>=1)

Ports:
- clk  in  1  system clock, rising edge
- nRst  in  1  asynchronous active-low reset
- req  in  N_REQ  per-requester request level; held until granted
- address_in  in  N_REQ*8  requester k address at [8k+7:8k]
- opcode_in  in  N_REQ*3  requester k opcode at [3k+2:3k]
- data_in  in  N_REQ*62  requester k data at [62k+61:62k]
- grant  out  N_REQ  one-hot, 1-cycle pulse when a requester's frame is captured
- busy  out  1  high from grant until the end of the guard gap
- done  out  1  1-cycle pulse after the last data bit leaves `tx`
- tx  out  1  serial line; idle high

Behaviour:
- Clock and reset: single clock `clk`; `nRst` is asynchronous and active-low.
- Reset values: tx=1, grant=0, busy=0, done=0, state=IDLE, rr pointer=0 (requester 0 highest priority next).
- Frame format, one bit per clock, MSB first:
  - start bit 0
  - address[7:0]
  - opcode[2:0]
  - data[61:0]
  - Total 74 cycles, i.e. the 73-bit payload plus the start bit.
- State machine: IDLE -> SHIFT -> GAP -> IDLE.
- IDLE:
  - tx=1.
  - At an edge with |req: pick winner w (round-robin, search starting at pointer). Register grant=onehot(w), load 73-bit shift reg {address,opcode,data} of w, tx<=0 (start bit), busy<=1, bit counter<=72, pointer<=(w+1) mod N_REQ, go to SHIFT.
  - Latency: req sampled at edge t -> grant and start bit both visible in cycle t+1.
- SHIFT:
  - grant returns to 0. Each cycle tx<=shreg[72] and shreg shifts left.
  - Counter decrements; after 73 payload bits go to GAP.
- GAP:
  - tx=1 for exactly GAP cycles.
  - done pulses in the first GAP cycle.
  - busy drops at the end of the last GAP cycle; return to IDLE.
- Request handling:
  - req changes during SHIFT/GAP are ignored; input data is sampled only at the grant edge.
  - A requester that drops req before grant is withdrawn.
  - A requester still holding req after grant is treated as a new request. It competes again only after the gap; round-robin passes it over while others request.
- Simultaneous requests: the lowest index at or above the pointer wins, wrapping.
- Reset mid-frame: tx returns to 1 immediately (asynchronous); the frame is abandoned with no done pulse.
- Back-to-back: minimum frame-to-frame period is 74+GAP cycles.

Optional Feature:
- PBUS_ARB_FIXED_PRI_EN defined: fixed priority, the lowest index always wins; the pointer is removed.
- Undefined: round-robin as above.

Decomposition:
- Package pbus_pkg:
  - ADDR_W=8, OP_W=3, DATA_W=62, FRAME_W=73
  - state enum {IDLE, SHIFT, GAP}
  - opcode constants shared with pctrl
- Sub-module pbus_rr_pick: combinational N_REQ round-robin/fixed picker (req, pointer -> one-hot grant, index). The macro selects its mode.

Test Plan:
- Single request: req[0]=1 with address 8'hAA, opcode 3'h4, data 62'd100 -> grant=4'b0001 for one cycle. tx then carries 0, 10101010, 100, then 62'd100 MSB first over 74 cycles. done fires one cycle later, then tx=1 for 2 cycles.
- Simultaneous requests: req=4'b1011 held -> grants in order 0, 1, 3, 0. Each frame starts 76 cycles after the previous one.
- Late request during a frame: req[2] rises in SHIFT cycle 10 -> no grant until IDLE. grant[2] is asserted one cycle after GAP ends; no frame overlap on tx.
- Reset mid-frame: nRst low at SHIFT cycle 30 -> tx=1, busy=0 asynchronously, no done. After release, pending req[3] with pointer=0 is granted.
- Withdrawn request: req[1] pulses high only during GAP -> never granted; tx stays 1.
- With PBUS_ARB_FIXED_PRI_EN, req=4'b0011 held -> requester 0 is granted every frame; requester 1 is starved.
